// File: rtl/updown_modulo_counter.sv
// Up/down modulo-N counter with load/hold and terminal-count pulse.
// Define UDCNT_BCD_EN to build in the double-dabble BCD converter for bcd_out.
module updown_modulo_counter #(
  parameter int WIDTH      = 8,
  parameter int MODULUS    = 256,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_down,
  input  logic                    hold,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_val,
  output logic [WIDTH-1:0]        count,
  output logic                    tc,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    bcd_valid,
  output logic                    bcd_busy
);

  // MODULUS may equal 2**WIDTH, so the load clamp compares one bit wider.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX   = MAX_W[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        count <= ({1'b0, load_val} < MOD_W) ? load_val : MAX;
      end else if (!hold && en) begin
        if (up_down) begin
          if (count == MAX) begin
            count <= '0;
            tc    <= 1'b1;
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            count <= MAX;
            tc    <= 1'b1;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
      end
    end
  end

`ifdef UDCNT_BCD_EN
  localparam int SW = 4*BCD_DIGITS;
  localparam int IW = $clog2(WIDTH+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]          state;
  logic [WIDTH-1:0]    snapshot;
  logic [SW+WIDTH-1:0] sr;
  logic [SW+WIDTH-1:0] adj;
  logic [IW-1:0]       iter;

  // Add-3 correction on every BCD digit before the shift.
  always_comb begin
    adj = sr;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (adj[WIDTH+4*d +: 4] >= 4'd5)
        adj[WIDTH+4*d +: 4] = adj[WIDTH+4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      snapshot  <= '0;
      sr        <= '0;
      iter      <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      bcd_busy  <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != snapshot) begin
            snapshot <= count;
            sr       <= {{SW{1'b0}}, count};
            iter     <= '0;
            bcd_busy <= 1'b1;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sr   <= {adj[SW+WIDTH-2:0], 1'b0};
          iter <= iter + IW'(1);
          if (iter == IW'(WIDTH-1)) state <= S_DONE;
        end
        S_DONE: begin
          bcd_out   <= sr[SW+WIDTH-1 -: SW];
          bcd_valid <= 1'b1;
          bcd_busy  <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign bcd_out   = '0;
  assign bcd_valid = 1'b0;
  assign bcd_busy  = 1'b0;
`endif

endmodule
